// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - multi-channel button synchronizer, debouncer and edge/auto-repeat pulse generator
//
// Optional feature: define BTN_AUTOREPEAT_EN to build the per-channel
// auto-repeat counters; without it btn_repeat is constant 0.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   btn_raw      unsynchronized board button pins (NUM_BTN)
//   btn_level    debounced active-high button state
//   btn_press    one-cycle pulse on btn_level 0->1
//   btn_release  one-cycle pulse on btn_level 1->0
//   btn_repeat   one-cycle auto-repeat pulse while held
module btn_conditioner #(
  parameter int                 NUM_BTN         = 7,
  parameter int                 DEBOUNCE_CYCLES = 32500,
  parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = NUM_BTN'(1),
  parameter int                 REPEAT_DELAY    = 1625000,
  parameter int                 REPEAT_PERIOD   = 325000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The entry cycle already counts as one stable sample, and the transition
  // edge itself is the last, so the counter only has to reach D-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] s;

  state_t             state_q [NUM_BTN];
  state_t             state_d [NUM_BTN];
  logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;

  assign s = sync2_q ^ ACTIVE_LOW_MASK;

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      level_d[i]   = level_q[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (s[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= CNT_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        HELD: begin
          if (!s[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (s[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= CNT_LAST) begin
            state_d[i]   = IDLE;
            cnt_d[i]     = '0;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
          level_d[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

  logic [RPT_W-1:0]   rpt_cnt_q [NUM_BTN];
  logic [RPT_W-1:0]   rpt_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] rpt_first_q, rpt_first_d; // first repeat already issued
  logic [NUM_BTN-1:0] repeat_q, repeat_d;

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      rpt_cnt_d[i]   = rpt_cnt_q[i];
      rpt_first_d[i] = rpt_first_q[i];
      repeat_d[i]    = 1'b0;
      if (state_q[i] == PRESS_WAIT && state_d[i] == HELD) begin
        // A fresh press restarts the delay; returning from RELEASE_WAIT
        // resumes the paused count instead.
        rpt_cnt_d[i]   = '0;
        rpt_first_d[i] = 1'b0;
      end else if (state_q[i] == HELD) begin
        if (rpt_cnt_q[i] + RPT_ONE == (rpt_first_q[i] ? RPT_PERIOD : RPT_DELAY)) begin
          repeat_d[i]    = 1'b1;
          rpt_cnt_d[i]   = '0;
          rpt_first_d[i] = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_first_q <= '0;
      repeat_q    <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      rpt_first_q <= rpt_first_d;
      repeat_q    <= repeat_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end

  assign btn_repeat = repeat_q;
`else
  assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed self-checking bench for btn_conditioner
module tb_btn_conditioner;

  localparam int NB = 7;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_repeat;

  int total;
  int bad;

  // Idle raw pattern: channel 0 is active-low, so released means 1.
  localparam logic [NB-1:0] RAW_IDLE = 7'b0000001;

  btn_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW_MASK(7'b0000001),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    btn_raw = RAW_IDLE;
    #3;
    total++;
    if ({btn_level, btn_press, btn_release, btn_repeat} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {btn_level, btn_press, btn_release, btn_repeat});
    end
    step;
    step;
    total++;
    if ({btn_level, btn_press, btn_release, btn_repeat} !== '0) begin
      bad++;
      $display("FAIL reset_held got=%h want=0", {btn_level, btn_press, btn_release, btn_repeat});
    end
    rst_n = 1'b1;
    // Channel 0 sees a 2-cycle inverted glitch right after reset; it must be filtered.
    for (int c = 1; c <= 10; c++) begin
      step;
      total++;
      if (btn_level !== '0 || btn_press !== '0) begin
        bad++;
        $display("FAIL post_reset_quiet c=%0d level=%b press=%b want=0", c, btn_level, btn_press);
      end
    end
  endtask

  task automatic test_clean_press;
    logic [NB-1:0] exp_p;
    btn_raw[1] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step;
      exp_p = (c == 6) ? 7'b0000010 : 7'b0;
      total++;
      if (btn_press !== exp_p || btn_level[1] !== (c >= 6)) begin
        bad++;
        $display("FAIL clean_press c=%0d press=%b level1=%b want press=%b level1=%b",
                 c, btn_press, btn_level[1], exp_p, (c >= 6));
      end
    end
    btn_raw[1] = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step;
      exp_p = (c == 6) ? 7'b0000010 : 7'b0;
      total++;
      if (btn_release !== exp_p || btn_press !== '0 || btn_level[1] !== (c < 6)) begin
        bad++;
        $display("FAIL clean_release c=%0d rel=%b press=%b level1=%b want rel=%b level1=%b",
                 c, btn_release, btn_press, btn_level[1], exp_p, (c < 6));
      end
    end
  endtask

  task automatic test_bounce;
    int n_press;
    int at;
    for (int k = 0; k < 4; k++) begin
      btn_raw[2] = (k % 2 == 0);
      step;
      total++;
      if (btn_press !== '0 || btn_level !== '0) begin
        bad++;
        $display("FAIL bounce_quiet k=%0d press=%b level=%b want 0", k, btn_press, btn_level);
      end
    end
    btn_raw[2] = 1'b1;
    n_press = 0;
    at = -1;
    for (int c = 1; c <= 12; c++) begin
      step;
      if (btn_press[2]) begin
        n_press++;
        at = c;
      end
    end
    total++;
    if (n_press != 1 || at != 6) begin
      bad++;
      $display("FAIL bounce_press count=%0d at=%0d want count=1 at=6", n_press, at);
    end
    btn_raw[2] = 1'b0;
    for (int c = 1; c <= 8; c++) step;
    total++;
    if (btn_level !== '0) begin
      bad++;
      $display("FAIL bounce_cleanup level=%b want 0", btn_level);
    end
  endtask

  task automatic test_active_low;
    btn_raw[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step;
      total++;
      if (btn_press !== ((c == 6) ? 7'b0000001 : 7'b0)) begin
        bad++;
        $display("FAIL active_low_press c=%0d press=%b want=%b", c, btn_press,
                 (c == 6) ? 7'b0000001 : 7'b0);
      end
    end
    btn_raw[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step;
      total++;
      if (btn_release !== ((c == 6) ? 7'b0000001 : 7'b0) || btn_level[0] !== (c < 6)) begin
        bad++;
        $display("FAIL active_low_release c=%0d rel=%b level0=%b want rel=%b level0=%b", c,
                 btn_release, btn_level[0], (c == 6) ? 7'b0000001 : 7'b0, (c < 6));
      end
    end
  endtask

  task automatic test_reset_mid_hold;
    btn_raw[3] = 1'b1;
    for (int c = 1; c <= 8; c++) step;
    total++;
    if (btn_level !== 7'b0001000) begin
      bad++;
      $display("FAIL hold_before_reset level=%b want=0001000", btn_level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({btn_level, btn_press, btn_release, btn_repeat} !== '0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", {btn_level, btn_press, btn_release, btn_repeat});
    end
    step;
    step;
    total++;
    if (btn_release !== '0 || btn_level !== '0) begin
      bad++;
      $display("FAIL reset_no_release rel=%b level=%b want 0", btn_release, btn_level);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step;
      total++;
      if (btn_press !== ((c == 6) ? 7'b0001000 : 7'b0) || btn_release !== '0) begin
        bad++;
        $display("FAIL repress_after_reset c=%0d press=%b rel=%b want press=%b", c,
                 btn_press, btn_release, (c == 6) ? 7'b0001000 : 7'b0);
      end
    end
    btn_raw[3] = 1'b0;
    for (int c = 1; c <= 8; c++) step;
  endtask

  task automatic test_autorepeat;
    logic [NB-1:0] exp_r;
    btn_raw[4] = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      step;
`ifdef BTN_AUTOREPEAT_EN
      exp_r = (c == 16 || c == 19 || c == 22 || c == 25) ? 7'b0010000 : 7'b0;
`else
      exp_r = 7'b0;
`endif
      total++;
      if (btn_repeat !== exp_r || btn_press !== ((c == 6) ? 7'b0010000 : 7'b0)) begin
        bad++;
        $display("FAIL autorepeat_hold c=%0d rep=%b press=%b want rep=%b press=%b", c,
                 btn_repeat, btn_press, exp_r, (c == 6) ? 7'b0010000 : 7'b0);
      end
    end
    btn_raw[4] = 1'b0;
    // The channel stays HELD for two more edges, so the absolute cycle 28 pulse still fires.
    for (int c = 1; c <= 8; c++) begin
      step;
`ifdef BTN_AUTOREPEAT_EN
      exp_r = (c == 2) ? 7'b0010000 : 7'b0;
`else
      exp_r = 7'b0;
`endif
      total++;
      if (btn_repeat !== exp_r || btn_release !== ((c == 6) ? 7'b0010000 : 7'b0)) begin
        bad++;
        $display("FAIL autorepeat_release c=%0d rep=%b rel=%b want rep=%b rel=%b", c,
                 btn_repeat, btn_release, exp_r, (c == 6) ? 7'b0010000 : 7'b0);
      end
    end
  endtask

  task automatic test_simultaneous;
    btn_raw[6:5] = 2'b11;
    for (int c = 1; c <= 8; c++) begin
      step;
      total++;
      if (btn_press !== ((c == 6) ? 7'b1100000 : 7'b0)) begin
        bad++;
        $display("FAIL simul_press c=%0d press=%b want=%b", c, btn_press,
                 (c == 6) ? 7'b1100000 : 7'b0);
      end
    end
    btn_raw[6:5] = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      step;
      total++;
      if (btn_release !== ((c == 6) ? 7'b1100000 : 7'b0) || btn_press !== '0) begin
        bad++;
        $display("FAIL simul_release c=%0d rel=%b press=%b want rel=%b", c, btn_release,
                 btn_press, (c == 6) ? 7'b1100000 : 7'b0);
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    btn_raw = RAW_IDLE;
    test_reset;
    test_clean_press;
    test_bounce;
    test_active_low;
    test_reset_mid_hold;
    test_autorepeat;
    test_simultaneous;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
